pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that generalises the fixed-width stall/flush inter-stage latch into a valid/ready handshaked stage with configurable payload width, configurable bubble value and an optional 2-entry skid buffer. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Upstream pushes `{pc_4, inst, ...}` payloads, and downstream consumes them under backpressure. Flush replaces the stage contents with a bubble.

---
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and stall gating.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
   parameter int               WIDTH  = 41,
   parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(41'h20)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   // Encoding equals the number of held entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic             in_fire;
   logic             out_fire;

   assign out_valid = (state_q != EMPTY);
   assign out_fire  = out_valid & out_ready & ~stall;
   assign in_fire   = in_valid & in_ready;
   assign out_data  = out_valid ? main_q : BUBBLE;

`ifdef PIPE_STAGE_SKID_EN
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;

   assign in_ready  = in_ready_q;
   assign occupancy = state_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  skid_d  = in_data;
                  state_d = SKID;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = FULL;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
      // Registered so upstream never sees a path from out_ready/stall.
      in_ready_d = (state_d != SKID);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end
`else
   // Single entry: a new payload is only accepted when the current one leaves.
   assign in_ready  = ~out_valid | (out_ready & ~stall);
   assign occupancy = {1'b0, out_valid};

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = FULL;
               end
            end
            FULL: begin
               if (in_fire) begin
                  main_d = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model compared every cycle, plus directed literal checks.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID_BUILD = 1'b1;
`else
   localparam bit SKID_BUILD = 1'b0;
`endif
   localparam logic [40:0] BUB = 41'h20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0, stall = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [40:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [40:0] out_data;
   logic [1:0]  occupancy;

   int passed = 0;
   int total  = 0;

   logic [40:0] mq[$];    // model contents, head = oldest
   logic [40:0] olog[$];  // payloads seen leaving the DUT
   bit          saw_dead = 1'b0;

   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [40:0] pl(input int hi, input int lo);
      logic [8:0]  h;
      logic [31:0] l;
      h = hi[8:0];
      l = lo[31:0];
      return {h, l};
   endfunction

   function automatic bit m_in_ready();
      if (SKID_BUILD) return mq.size() < 2;
      return (mq.size() == 0) || (out_ready && !stall);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a FIFO of at most 1 or 2 entries; flush empties it.
   always @(posedge clk or posedge rst) begin : model
      bit of, inf;
      if (rst) begin
         mq.delete();
      end else begin
         of  = (mq.size() > 0) && out_ready && !stall;
         inf = in_valid && m_in_ready();
         if (flush) begin
            mq.delete();
         end else begin
            if (of) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      chk("cyc_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("cyc_out_data", 64'(out_data), 64'((mq.size() > 0) ? mq[0] : BUB));
      chk("cyc_occupancy", 64'(occupancy), 64'(mq.size()));
      chk("cyc_in_ready", 64'(in_ready), 64'(m_in_ready()));
      if (!rst && out_valid && out_ready && !stall) olog.push_back(out_data);
      if (out_data == pl(9'h0FF, 32'hDEADBEEF)) saw_dead = 1'b1;
   end

   task automatic set_in(input logic iv, input logic [40:0] d, input logic ordy,
                         input logic stl, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      stall     = stl;
      flush     = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_in(0, '0, 1, 0, 0);
      repeat (3) tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'h20);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) tick();
      rst = 1'b0;

      // Streaming, 10 payloads back to back.
      olog.delete();
      for (int i = 1; i <= 10; i++) begin
         set_in(1, pl(i, i), 1, 0, 0);
         tick();
         if (i == 1) begin
            chk("lat_out_valid", 64'(out_valid), 64'd1);
            chk("lat_out_data", 64'(out_data), 64'h001_00000001);
         end
      end
      drain();
      chk("stream_count", 64'(olog.size()), 64'd10);
      for (int i = 0; i < olog.size() && i < 10; i++)
         chk($sformatf("stream_%0d", i), 64'(olog[i]), 64'(pl(i + 1, i + 1)));

      // FULL with in_fire and out_fire together.
      set_in(1, 41'h011_11111111, 0, 0, 0);
      tick();
      set_in(1, 41'h022_22222222, 1, 0, 0);
      tick();
      chk("both_occupancy", 64'(occupancy), 64'd1);
      chk("both_out_data", 64'(out_data), 64'h022_22222222);
      drain();

      // Stall for three cycles while upstream keeps offering.
      olog.delete();
      set_in(1, 41'h0C1_000000C1, 1, 1, 0);
      tick();
      chk("stall_occ1", 64'(occupancy), 64'd1);
      set_in(1, 41'h0C2_000000C2, 1, 1, 0);
      #1;
      chk("stall_in_ready_now", 64'(in_ready), 64'(SKID_BUILD));
      tick();
      if (SKID_BUILD) begin
         chk("stall_occ2", 64'(occupancy), 64'd2);
         chk("stall_ready_low", 64'(in_ready), 64'd0);
         set_in(1, 41'h0C3_000000C3, 1, 1, 0);
         tick();
         set_in(1, 41'h0C3_000000C3, 1, 0, 0);
         tick();
         chk("skid_pop_data", 64'(out_data), 64'h0C2_000000C2);
         chk("skid_pop_occ", 64'(occupancy), 64'd1);
         set_in(1, 41'h0C3_000000C3, 1, 0, 0);
         tick();
      end else begin
         chk("stall_hold_data", 64'(out_data), 64'h0C1_000000C1);
         set_in(1, 41'h0C2_000000C2, 1, 1, 0);
         tick();
         set_in(1, 41'h0C2_000000C2, 1, 0, 0);
         tick();
         chk("release_data", 64'(out_data), 64'h0C2_000000C2);
      end
      drain();
      chk("stall_count", 64'(olog.size()), SKID_BUILD ? 64'd3 : 64'd2);
      for (int i = 0; i < olog.size() && i < 3; i++)
         chk($sformatf("stall_order_%0d", i), 64'(olog[i]), 64'(pl(9'h0C1 + i, 32'hC1 + i)));

      // Flush with entries held and a coincident push.
      saw_dead = 1'b0;
      set_in(1, 41'h0F1_000000F1, 0, 0, 0);
      tick();
      set_in(1, 41'h0F2_000000F2, 0, 0, 0);
      tick();
      set_in(1, 41'h0FF_DEADBEEF, 0, 0, 1);
      tick();
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_out_data", 64'(out_data), 64'h20);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      drain();
      chk("flush_no_dead", 64'(saw_dead), 64'd0);

      // Asynchronous reset mid-stream.
      set_in(1, 41'h0A1_000000A1, 0, 0, 0);
      tick();
      set_in(1, 41'h0A2_000000A2, 0, 0, 0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_data", 64'(out_data), 64'h20);
      chk("arst_occupancy", 64'(occupancy), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      tick();
      rst = 1'b0;
      set_in(1, 41'h0B1_000000B1, 1, 0, 0);
      tick();
      chk("post_rst_data", 64'(out_data), 64'h0B1_000000B1);
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
